interval_timer: RTL
===================

Name: interval_timer

Overview:
- CPU-visible programmable interval timer. It is the consumer end of the timer clock that the clock divider generates.
- Samples TIMERCLK in the MCLK_IN domain and counts its rising edges as ticks.
- Decrements a reload counter on each tick and raises a level interrupt to the 68000 interrupt encoder on expiry.
- Register access uses a simple 68000-style CS/RW/DTACK handshake from the bus glue.

Parameters:
- WIDTH, 16, counter, reload and data width.
- RELOAD_DEFAULT, 16'd999, reset value of RELOAD (1000 ticks per period, nominal 1 ms).

Ports:
- MCLK_IN  in  1  master clock (40 MHz); all state on posedge.
- RESET  in  1  asynchronous, active-high reset.
- TIMERCLK  in  1  divided timer clock; treated as a level and edge-detected.
- CS  in  1  chip select; access request while high.
- RW  in  1  1 = read, 0 = write.
- ADDR  in  2  register select.
- WDATA  in  WIDTH  write data.
- RDATA  out  WIDTH  read data; valid while DTACK is high.
- DTACK  out  1  transfer acknowledge.
- IACK  in  1  one-cycle interrupt acknowledge pulse; clears EXPIRED.
- IRQ  out  1  registered interrupt request.

Behaviour:
- Interface fact: one clock, MCLK_IN. Reset RESET is asynchronous, active-high.
- Reset values:
  - CTRL=0, COUNT=0, RELOAD=RELOAD_DEFAULT, EXPIRED=0.
  - IRQ=0, DTACK=0, RDATA=0.
  - Sync flops and bus FSM cleared to IDLE.
  - Reset asserted mid-access drops DTACK immediately.
- Tick detection:
  - TIMERCLK passes through SYNC1 -> SYNC2 -> PREV.
  - tick = SYNC2 & ~PREV, one MCLK_IN cycle wide.
  - A TIMERCLK rise produces a tick 2 cycles later; its effect on COUNT is visible 3 cycles later.
- Register map:
  - 0 CTRL: [0]EN, [1]IE, [2]ONESHOT; other bits read 0.
  - 1 RELOAD: read/write.
  - 2 COUNT: reads the live count; a write loads COUNT directly.
  - 3 STATUS: [0]EXPIRED; write 1 clears, write 0 has no effect.
- Counting, on each tick with EN=1:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: COUNT <= RELOAD, EXPIRED <= 1, and EN <= 0 if ONESHOT=1.
  - Ticks with EN=0 are ignored.
  - The period is RELOAD+1 ticks.
  - RELOAD=0 expires on every tick.
  - No wrap below 0.
- Register-write side effects:
  - Writing RELOAD never touches the running COUNT.
  - Setting EN 0->1 does not reload COUNT.
- IRQ:
  - IRQ <= EXPIRED & IE, registered, so it rises 1 cycle after EXPIRED or IE goes high.
  - Clearing IE drops IRQ on the next cycle; EXPIRED is kept.
- Clearing EXPIRED:
  - IACK high clears EXPIRED.
  - A STATUS write with bit0=1 also clears it.
- Simultaneous events:
  - Expiry and a clear (IACK or W1C) in the same cycle: set wins, EXPIRED stays 1.
  - COUNT write and tick in the same cycle: the write wins and the tick is lost.
  - CTRL write and a ONESHOT auto-clear in the same cycle: the written value wins.
- Bus FSM:
  - IDLE --CS=1--> ACK: in this cycle the write is committed (or RDATA is latched from the addressed register), and DTACK <= 1.
  - ACK -> HOLD. In HOLD, DTACK stays 1 while CS=1.
  - HOLD --CS=0--> IDLE: DTACK <= 0 and RDATA <= 0.
  - Exactly one commit per CS assertion, however long CS is held.
  - CS dropped during ACK still completes the access, then returns to IDLE.

Decomposition:
- Shared package timer_pkg holds:
  - Register address constants ADDR_CTRL=0, ADDR_RELOAD=1, ADDR_COUNT=2, ADDR_STATUS=3.
  - CTRL bit indices.
  - Bus FSM state encoding: IDLE, ACK, HOLD.
- One sub-module: tick_sync. It is the 2-flop synchronizer plus rising-edge detector and emits a one-cycle tick. It is reusable for other divided clocks.

Test Plan:
- Reset release with TIMERCLK idle:
  - Read addr 1 -> RDATA=999, with DTACK rising 1 cycle after CS.
  - Read addr 3 -> 0.
  - IRQ=0.
- Periodic mode:
  - Write RELOAD=3, COUNT=3, CTRL=3 (EN, IE), then apply 4 TIMERCLK rises.
  - Required: after the 4th rise COUNT=3 (reloaded), EXPIRED=1, and IRQ goes high one cycle after EXPIRED.
- Clear paths:
  - With IRQ high, pulse IACK -> EXPIRED=0, then IRQ=0 next cycle.
  - Repeat with a write of 1 to addr 3 -> same result.
  - A write of 0 to addr 3 -> EXPIRED stays 1.
- One-shot:
  - CTRL=7, RELOAD=1, COUNT=1; apply 2 ticks -> EXPIRED=1 and CTRL reads 6.
  - 5 further ticks -> COUNT stays 1.
- Collisions:
  - STATUS W1C committed in the same cycle as an expiry tick -> EXPIRED remains 1.
  - COUNT write of 10 in the same cycle as a tick -> COUNT reads 10.
- Bus and reset:
  - CS held high for 20 cycles on a write of RELOAD=5 -> single commit, DTACK high until CS falls.
  - RESET asserted mid-HOLD -> DTACK=0 at once and RELOAD=999 after reset.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: register map, CTRL bit layout, bus FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package timer_pkg;

  // Register addresses on the 2-bit ADDR bus
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

  // STATUS register bit positions
  localparam int STATUS_EXPIRED = 0;

  // Bus handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } bus_state_t;

  // Packs the CTRL fields into their register bit positions
  function automatic logic [2:0] ctrl_pack(input logic en, input logic ie, input logic oneshot);
    logic [2:0] v;
    v = '0;
    v[CTRL_EN]      = en;
    v[CTRL_IE]      = ie;
    v[CTRL_ONESHOT] = oneshot;
    return v;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronises a slow level input into MCLK_IN and emits a one-cycle pulse per rising edge.
// Latency: the pulse is high during the second cycle after the input rise is first sampled.
// Backpressure: none; every qualifying rising edge produces exactly one pulse.
module tick_sync (
  input  logic MCLK_IN,
  input  logic RESET,
  input  logic level_in,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= level_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign tick = sync2 & ~prev;

endmodule

// File: rtl/interval_timer.sv
// CPU-visible programmable interval timer counting synchronised TIMERCLK rising edges.
// Latency: DTACK and RDATA one cycle after CS; tick effect on COUNT 3 cycles after TIMERCLK rises.
// Backpressure: DTACK held while CS stays high; one commit per CS assertion.
module interval_timer
  import timer_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] RELOAD_DEFAULT = 16'd999
) (
  input  logic             MCLK_IN,
  input  logic             RESET,
  input  logic             TIMERCLK,
  input  logic             CS,
  input  logic             RW,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             DTACK,
  input  logic             IACK,
  output logic             IRQ
);

  logic             tick;
  bus_state_t       state;
  bus_state_t       state_nxt;
  logic             wr_commit;
  logic             dtack_nxt;
  logic [WIDTH-1:0] rdata_nxt;
  logic [WIDTH-1:0] rd_mux;

  logic             ctrl_en;
  logic             ctrl_ie;
  logic             ctrl_oneshot;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] count_q;
  logic             expired_q;

  logic             wr_ctrl;
  logic             wr_reload;
  logic             wr_count;
  logic             wr_status;
  logic             expire;
  logic             status_clear;

  tick_sync u_tick_sync (
    .MCLK_IN  (MCLK_IN),
    .RESET    (RESET),
    .level_in (TIMERCLK),
    .tick     (tick)
  );

  // Bus handshake state register
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus next state, single write-commit strobe, and next DTACK/RDATA values
  always_comb begin
    state_nxt = state;
    wr_commit = 1'b0;
    dtack_nxt = DTACK;
    rdata_nxt = RDATA;
    case (state)
      IDLE: begin
        if (CS) begin
          state_nxt = ACK;
          wr_commit = ~RW;
          dtack_nxt = 1'b1;
          rdata_nxt = RW ? rd_mux : '0;
        end
      end
      // CS may already be low here; the access still finishes through HOLD
      ACK: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!CS) begin
          state_nxt = IDLE;
          dtack_nxt = 1'b0;
          rdata_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        dtack_nxt = 1'b0;
        rdata_nxt = '0;
      end
    endcase
  end

  // Registered bus outputs; reset clears DTACK immediately even mid-access
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      DTACK <= 1'b0;
      RDATA <= '0;
    end else begin
      DTACK <= dtack_nxt;
      RDATA <= rdata_nxt;
    end
  end

  // Read data selection from the addressed register
  always_comb begin
    rd_mux = '0;
    case (ADDR)
      ADDR_CTRL:   rd_mux[2:0] = ctrl_pack(ctrl_en, ctrl_ie, ctrl_oneshot);
      ADDR_RELOAD: rd_mux = reload_q;
      ADDR_COUNT:  rd_mux = count_q;
      ADDR_STATUS: rd_mux[STATUS_EXPIRED] = expired_q;
      default:     rd_mux = '0;
    endcase
  end

  assign wr_ctrl   = wr_commit && (ADDR == ADDR_CTRL);
  assign wr_reload = wr_commit && (ADDR == ADDR_RELOAD);
  assign wr_count  = wr_commit && (ADDR == ADDR_COUNT);
  assign wr_status = wr_commit && (ADDR == ADDR_STATUS);

  // A direct COUNT write swallows a coincident tick, including any expiry it would cause
  assign expire       = tick && ctrl_en && (count_q == '0) && !wr_count;
  assign status_clear = IACK || (wr_status && WDATA[STATUS_EXPIRED]);

  // CTRL register; a software write overrides the one-shot auto-disable
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en      <= WDATA[CTRL_EN];
      ctrl_ie      <= WDATA[CTRL_IE];
      ctrl_oneshot <= WDATA[CTRL_ONESHOT];
    end else if (expire && ctrl_oneshot) begin
      ctrl_en      <= 1'b0;
    end
  end

  // RELOAD register; writing it leaves the running count alone
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      reload_q <= RELOAD_DEFAULT;
    end else if (wr_reload) begin
      reload_q <= WDATA;
    end
  end

  // Down-counter: decrement per enabled tick, reload on the tick after reaching zero
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= WDATA;
    end else if (tick && ctrl_en) begin
      if (count_q != '0) begin
        count_q <= count_q - 1'b1;
      end else begin
        count_q <= reload_q;
      end
    end
  end

  // Sticky expiry flag; a new expiry beats a simultaneous clear
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      expired_q <= 1'b0;
    end else if (expire) begin
      expired_q <= 1'b1;
    end else if (status_clear) begin
      expired_q <= 1'b0;
    end
  end

  // Registered interrupt request to the interrupt encoder
  always_ff @(posedge MCLK_IN or posedge RESET) begin
    if (RESET) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= expired_q & ctrl_ie;
    end
  end

endmodule
